// File: rtl/turn_control.sv
// Game-sequencing FSM in front of data_path: turns player flips into compare/advance
// strobes and a next-turn pulse, and tracks the cards face-up in the current turn.
module turn_control #(
  parameter int unsigned NUM_CARDS     = 12,
  parameter int unsigned REVEAL_CYCLES = 50000000,
  parameter int unsigned TW            = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flip_req,
  input  logic [3:0]           flip_idx,
  input  logic                 go,
  input  logic                 W,
  output logic                 A,
  output logic                 B,
  output logic                 statecombo_next_turn,
  output logic [NUM_CARDS-1:0] card_open,
  output logic [3:0]           cur_card,
  output logic                 game_over,
  output logic [2:0]           state
);

  localparam int unsigned IW    = 4;
  localparam int unsigned SLOTS = 1 << IW;
  localparam logic [TW-1:0]        TIMER_LAST = TW'(REVEAL_CYCLES - 1);
  localparam logic [NUM_CARDS-1:0] ALL_OPEN   = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_REVEAL = 3'd2,
    S_CMP    = 3'd3,
    S_JUDGE  = 3'd4,
    S_MOVE   = 3'd5,
    S_MCHK   = 3'd6,
    S_WIN    = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NUM_CARDS-1:0] open_d;
  logic [IW-1:0]        cur_d;
  logic                 next_turn_d;
  logic [SLOTS-1:0]     open_ext;
  logic                 flip_ok;

  // Indices past the last card read as already open, so they are rejected for free.
  always_comb begin
    open_ext                 = '1;
    open_ext[NUM_CARDS-1:0]  = card_open;
    flip_ok                  = flip_req && !open_ext[flip_idx];
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    open_d      = card_open;
    cur_d       = cur_card;
    next_turn_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          open_d  = '0;
        end
      end
      S_SELECT: begin
        if (flip_ok) begin
          cur_d            = flip_idx;
          open_d[flip_idx] = 1'b1;
          timer_d          = '0;
          state_d          = S_REVEAL;
        end
      end
      S_REVEAL: begin
        if (timer_q == TIMER_LAST) state_d = S_CMP;
        else                       timer_d = timer_q + TW'(1);
      end
      S_CMP: state_d = S_JUDGE;
      S_JUDGE: begin
        if (go) begin
          state_d = S_MOVE;
        end else begin
          next_turn_d = 1'b1;
          open_d      = '0;
          state_d     = S_SELECT;
        end
      end
      S_MOVE: state_d = S_MCHK;
      S_MCHK: begin
        if (W) begin
          state_d = S_WIN;
        end else begin
          state_d = S_SELECT;
          // Board exhausted without a win: hand over to the next player with a fresh mask.
          if (card_open == ALL_OPEN) begin
            next_turn_d = 1'b1;
            open_d      = '0;
          end
        end
      end
      S_WIN: begin
        if (start) begin
          state_d = S_SELECT;
          open_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore strobes are registered from the state being entered, so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q              <= S_IDLE;
      timer_q              <= '0;
      card_open            <= '0;
      cur_card             <= '0;
      A                    <= 1'b0;
      B                    <= 1'b0;
      statecombo_next_turn <= 1'b0;
      game_over            <= 1'b0;
    end else begin
      state_q              <= state_d;
      timer_q              <= timer_d;
      card_open            <= open_d;
      cur_card             <= cur_d;
      A                    <= (state_d == S_CMP);
      B                    <= (state_d == S_MOVE);
      statecombo_next_turn <= next_turn_d;
      game_over            <= (state_d == S_WIN);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_turn_control.sv
// Directed self-checking bench for turn_control with a short reveal time.
module tb_turn_control;

  localparam int unsigned NC = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          flip_req = 1'b0;
  logic [3:0]    flip_idx = 4'd0;
  logic          go = 1'b0;
  logic          W = 1'b0;
  logic          A, B, next_turn, game_over;
  logic [NC-1:0] card_open;
  logic [3:0]    cur_card;
  logic [2:0]    state;

  int tests = 0;
  int fails = 0;

  turn_control #(.NUM_CARDS(NC), .REVEAL_CYCLES(4), .TW(26)) dut (
    .clk(clk), .rst(rst), .start(start), .flip_req(flip_req), .flip_idx(flip_idx),
    .go(go), .W(W), .A(A), .B(B), .statecombo_next_turn(next_turn),
    .card_open(card_open), .cur_card(cur_card), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full flip sequence with fixed latencies; ends one cycle after the JUDGE/MCHK decision.
  task automatic do_flip(input logic [3:0] idx, input logic go_v, input logic w_v);
    flip_req = 1'b1; flip_idx = idx;
    tick();
    flip_req = 1'b0;
    repeat (4) tick();
    go = go_v;
    tick();
    if (go_v) begin
      tick();
      W = w_v;
      tick();
    end
    tick();
    go = 1'b0; W = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    tests++; if ({A, B, next_turn, game_over} !== 4'b0) begin fails++; $display("FAIL reset_strobes: got %b expected 0000", {A, B, next_turn, game_over}); end
    tests++; if (card_open !== 12'h000) begin fails++; $display("FAIL reset_card_open: got %h expected 000", card_open); end
    tests++; if (cur_card !== 4'd0) begin fails++; $display("FAIL reset_cur_card: got %0d expected 0", cur_card); end
    rst = 1'b1;
    tick();
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL idle_wait: got %0d expected 0", state); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL start_select: got %0d expected 1", state); end
    tests++; if (card_open !== 12'h000) begin fails++; $display("FAIL start_card_open: got %h expected 000", card_open); end
  endtask

  task automatic test_mismatch();
    flip_req = 1'b1; flip_idx = 4'd5;
    tick();
    flip_req = 1'b0;
    tests++; if (card_open !== 12'h020) begin fails++; $display("FAIL mm_card_open: got %h expected 020", card_open); end
    tests++; if (state !== 3'd2) begin fails++; $display("FAIL mm_reveal: got %0d expected 2", state); end
    tests++; if (cur_card !== 4'd5) begin fails++; $display("FAIL mm_cur_card: got %0d expected 5", cur_card); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      tests++; if (A !== 1'b0) begin fails++; $display("FAIL mm_a_early: cycle %0d got %b expected 0", c, A); end
    end
    tick();
    tests++; if (A !== 1'b1 || state !== 3'd3) begin fails++; $display("FAIL mm_a_pulse: got A=%b state=%0d expected A=1 state=3", A, state); end
    go = 1'b0;
    tick();
    tests++; if (A !== 1'b0 || state !== 3'd4) begin fails++; $display("FAIL mm_judge: got A=%b state=%0d expected A=0 state=4", A, state); end
    tick();
    tests++; if (next_turn !== 1'b1) begin fails++; $display("FAIL mm_next_turn: got %b expected 1", next_turn); end
    tests++; if (card_open !== 12'h000 || state !== 3'd1) begin fails++; $display("FAIL mm_back_select: got open=%h state=%0d expected 000/1", card_open, state); end
    tick();
    tests++; if (next_turn !== 1'b0) begin fails++; $display("FAIL mm_next_turn_width: got %b expected 0", next_turn); end
  endtask

  task automatic test_match_continue();
    flip_req = 1'b1; flip_idx = 4'd2;
    tick();
    flip_req = 1'b0;
    tests++; if (card_open !== 12'h004) begin fails++; $display("FAIL mc_card_open: got %h expected 004", card_open); end
    repeat (4) tick();
    tests++; if (A !== 1'b1) begin fails++; $display("FAIL mc_a_pulse: got %b expected 1", A); end
    go = 1'b1;
    tick();
    tick();
    tests++; if (B !== 1'b1 || state !== 3'd5 || next_turn !== 1'b0) begin fails++; $display("FAIL mc_b_pulse: got B=%b state=%0d nt=%b expected 1/5/0", B, state, next_turn); end
    W = 1'b0;
    tick();
    tests++; if (B !== 1'b0 || state !== 3'd6) begin fails++; $display("FAIL mc_mchk: got B=%b state=%0d expected 0/6", B, state); end
    tick();
    go = 1'b0;
    tests++; if (state !== 3'd1 || card_open !== 12'h004 || next_turn !== 1'b0) begin fails++; $display("FAIL mc_continue: got state=%0d open=%h nt=%b expected 1/004/0", state, card_open, next_turn); end
  endtask

  task automatic test_reject();
    int a_seen;
    a_seen = 0;
    flip_req = 1'b1; flip_idx = 4'd2;
    tick();
    if (A) a_seen++;
    tests++; if (state !== 3'd1 || card_open !== 12'h004) begin fails++; $display("FAIL rej_open_card: got state=%0d open=%h expected 1/004", state, card_open); end
    flip_idx = 4'd13;
    tick();
    if (A) a_seen++;
    flip_req = 1'b0;
    tests++; if (state !== 3'd1 || card_open !== 12'h004 || cur_card !== 4'd2) begin fails++; $display("FAIL rej_range: got state=%0d open=%h cur=%0d expected 1/004/2", state, card_open, cur_card); end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (A) a_seen++;
    tests++; if (state !== 3'd1 || card_open !== 12'h004) begin fails++; $display("FAIL rej_start_in_select: got state=%0d open=%h expected 1/004", state, card_open); end
    repeat (6) begin tick(); if (A) a_seen++; end
    tests++; if (a_seen !== 0) begin fails++; $display("FAIL rej_no_a: got %0d A cycles expected 0", a_seen); end
  endtask

  task automatic test_win();
    do_flip(4'd7, 1'b1, 1'b1);
    tests++; if (state !== 3'd7 || game_over !== 1'b1) begin fails++; $display("FAIL win_state: got state=%0d go=%b expected 7/1", state, game_over); end
    tests++; if ({A, B, next_turn} !== 3'b000) begin fails++; $display("FAIL win_strobes: got %b expected 000", {A, B, next_turn}); end
    flip_req = 1'b1; flip_idx = 4'd9;
    tick();
    flip_req = 1'b0;
    tests++; if (state !== 3'd7 || card_open !== 12'h084) begin fails++; $display("FAIL win_flip_ignored: got state=%0d open=%h expected 7/084", state, card_open); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (state !== 3'd1 || game_over !== 1'b0 || card_open !== 12'h000) begin fails++; $display("FAIL win_restart: got state=%0d go=%b open=%h expected 1/0/000", state, game_over, card_open); end
  endtask

  task automatic test_all_open_guard();
    for (int i = 0; i < 11; i++) do_flip(4'(i), 1'b1, 1'b0);
    tests++; if (card_open !== 12'h7FF || next_turn !== 1'b0) begin fails++; $display("FAIL guard_partial: got open=%h nt=%b expected 7ff/0", card_open, next_turn); end
    do_flip(4'd11, 1'b1, 1'b0);
    tests++; if (next_turn !== 1'b1 || card_open !== 12'h000 || state !== 3'd1) begin fails++; $display("FAIL guard_handover: got nt=%b open=%h state=%0d expected 1/000/1", next_turn, card_open, state); end
  endtask

  task automatic test_async_reset();
    int a_seen;
    a_seen = 0;
    flip_req = 1'b1; flip_idx = 4'd3;
    tick();
    flip_req = 1'b0;
    tick();
    tests++; if (state !== 3'd2 || card_open !== 12'h008) begin fails++; $display("FAIL ar_pre: got state=%0d open=%h expected 2/008", state, card_open); end
    #2 rst = 1'b0;
    #1;
    tests++; if (state !== 3'd0 || card_open !== 12'h000) begin fails++; $display("FAIL ar_immediate: got state=%0d open=%h expected 0/000", state, card_open); end
    repeat (2) begin tick(); if (A) a_seen++; end
    rst = 1'b1;
    repeat (8) begin tick(); if (A) a_seen++; end
    tests++; if (a_seen !== 0 || state !== 3'd0) begin fails++; $display("FAIL ar_quiet: got A cycles=%0d state=%0d expected 0/0", a_seen, state); end
  endtask

  task automatic test_start_priority();
    start = 1'b1; flip_req = 1'b1; flip_idx = 4'd4;
    tick();
    start = 1'b0; flip_req = 1'b0;
    tests++; if (state !== 3'd1 || card_open !== 12'h000) begin fails++; $display("FAIL sp_start_wins: got state=%0d open=%h expected 1/000", state, card_open); end
  endtask

  initial begin
    test_reset();
    test_mismatch();
    test_match_continue();
    test_reject();
    test_win();
    test_all_open_guard();
    test_async_reset();
    test_start_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
